// File: rtl/f32m_mux6_sched_pkg.sv
// Shared constants and types for the GF(3^{2M}) operand-mux scheduler.
package f32m_mux6_sched_pkg;

  localparam int M           = 97;
  localparam int WIDTH       = 2 * M;
  localparam int W2          = 2 * WIDTH;
  localparam int N_REQ_DEF   = 6;
  localparam int TIMEOUT_DEF = 1023;
  localparam int TW_DEF      = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/f32m_mux6_sched_rr_pick.sv
// Combinational round-robin picker: first set req searching from last+1, wrapping.
module rr_pick #(
  parameter int N_REQ = 6,
  parameter int LW    = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] onehot,
  output logic [LW-1:0]    idx
);

  int   j;
  logic found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last) + k) % N_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = LW'(j);
      end
    end
  end

endmodule

// File: rtl/f32m_mux6_sched.sv
// Round-robin scheduler sharing one GF(3^{2M}) unit among N_REQ requesters;
// sel[i] drives select line li of the six-way operand mux.
module f32m_mux6_sched
  import f32m_mux6_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] sel,
  output logic             unit_start,
  input  logic             unit_done,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             timeout_err
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_n;
  logic [N_REQ-1:0] sel_n, ack_n, pick_oh;
  logic [LW-1:0]    last, last_n, cur, cur_n, pick_idx;
  logic [TW-1:0]    wd, wd_n;
  logic             start_n, err_n;

  rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
    .req    (req),
    .last   (last),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sel         <= '0;
      ack         <= '0;
      unit_start  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
      last        <= LW'(N_REQ - 1);
      cur         <= '0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      ack         <= ack_n;
      unit_start  <= start_n;
      busy        <= (state_n != S_IDLE);
      timeout_err <= err_n;
      wd          <= wd_n;
      last        <= last_n;
      cur         <= cur_n;
    end
  end

  // Outputs are computed for the state being entered so every port is a flop.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ack_n   = '0;
    start_n = 1'b0;
    err_n   = timeout_err;
    wd_n    = wd;
    last_n  = last;
    cur_n   = cur;
    case (state)
      S_IDLE: begin
        sel_n = '0;
        if (|req) begin
          state_n = S_GRANT;
          sel_n   = pick_oh;
          cur_n   = pick_idx;
          start_n = 1'b1;
        end
      end
      S_GRANT: begin
        wd_n    = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (unit_done) begin
          state_n = S_ACK;
          ack_n   = sel;
        end else if (wd == TW'(TIMEOUT - 1)) begin
          state_n = S_IDLE;
          sel_n   = '0;
          err_n   = 1'b1;
          last_n  = cur;
        end else begin
          wd_n = wd + TW'(1);
        end
      end
      S_ACK: begin
        last_n  = cur;
        sel_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_f32m_mux6_sched.sv
// Bench for f32m_mux6_sched: cycle-level reference model, directed scenarios, random soak.
module tb_f32m_mux6_sched;

  localparam int N  = 6;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] sel, ack;
  logic         unit_start, unit_done, busy, timeout_err;

  f32m_mux6_sched #(.N_REQ(N), .TIMEOUT(TO), .TW(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .sel         (sel),
    .unit_start  (unit_start),
    .unit_done   (unit_done),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: one operation = owner granted, start cycle, some wait
  // cycles, then either an ack cycle or an abort at the TO-th wait cycle.
  int cyc = 0;
  bit m_valid = 0;
  int m_own = -1;
  bit m_start = 0;
  bit m_ack = 0;
  bit m_err = 0;
  int m_last = N - 1;
  int m_wait = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1; m_own = -1; m_start = 0; m_ack = 0; m_err = 0;
      m_last = N - 1; m_wait = 0;
    end else if (!m_valid) begin
      m_own = -1;
    end else if (m_ack) begin
      m_last = m_own; m_own = -1; m_ack = 0;
    end else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_own < 0 && req[(m_last + k) % N]) m_own = (m_last + k) % N;
      end
      m_start = (m_own >= 0);
    end else if (m_start) begin
      m_start = 0; m_wait = 0;
    end else begin
      m_wait++;
      if (unit_done) m_ack = 1;
      else if (m_wait == TO) begin
        m_err = 1; m_last = m_own; m_own = -1;
      end
    end
  end

  int g_who[$];
  int g_cyc[$];
  int n_ack = 0;
  int terr_cyc = -1;

  always @(negedge clk) begin
    int e_sel;
    if (m_valid) begin
      e_sel = (m_own >= 0) ? (1 << m_own) : 0;
      chk("sel", int'(sel), e_sel);
      chk("unit_start", int'(unit_start), int'(m_start));
      chk("ack", int'(ack), m_ack ? e_sel : 0);
      chk("busy", int'(busy), (m_own >= 0) ? 1 : 0);
      chk("timeout_err", int'(timeout_err), int'(m_err));
      chk("sel_onehot", ($countones(sel) <= 1) ? 1 : 0, 1);
      chk("ack_in_sel", ((ack & ~sel) == '0) ? 1 : 0, 1);
      if (unit_start) begin
        for (int i = 0; i < N; i++) if (sel[i]) g_who.push_back(i);
        g_cyc.push_back(cyc);
      end
      if (ack != '0) n_ack++;
      if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
    end
  end

  // Shared-unit responder: 0 = manual, 1 = done dly cycles after start (0 = never), 2 = random
  int mode = 0;
  int dly = 1;
  int cnt = 0;
  bit man_done = 0;

  always @(negedge clk) begin
    case (mode)
      1: begin
        unit_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          unit_done = (cnt == 0);
        end
        if (unit_start) cnt = dly;
      end
      2:       unit_done = ($urandom_range(0, 2) == 0);
      default: unit_done = man_done;
    endcase
  end

  task automatic step(input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (drop) req = req & ~ack;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); #1;
    reset = 1'b1; req = '0;
    step(1, 0);
    reset = 1'b0;
    g_who.delete(); g_cyc.delete(); n_ack = 0; terr_cyc = -1;
  endtask

  int exp_rr[7] = '{0, 1, 2, 3, 4, 5, 0};
  int acks_at_err;

  initial begin
    unit_done = 1'b0;
    step(2, 0);
    reset = 1'b0;
    step(1, 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(timeout_err), 0);

    // single request, done three cycles after start
    mode = 1; dly = 3; req = 6'b000001;
    step(14, 1);
    chk("t1_grants", g_who.size(), 1);
    if (g_who.size() > 0) chk("t1_who", g_who[0], 0);
    chk("t1_acks", n_ack, 1);
    chk("t1_busy", int'(busy), 0);

    // all requesting, immediate done: strict rotation every 4 cycles
    reset_dut();
    mode = 1; dly = 1; req = 6'b111111;
    step(32, 0);
    req = '0;
    step(6, 0);
    chk("t2_count_ok", (g_who.size() >= 7) ? 1 : 0, 1);
    if (g_who.size() >= 7) begin
      for (int k = 0; k < 7; k++) chk($sformatf("t2_order%0d", k), g_who[k], exp_rr[k]);
      for (int k = 0; k < 6; k++) chk($sformatf("t2_space%0d", k), g_cyc[k+1] - g_cyc[k], 4);
    end

    // pointer wrap with requesters 0 and 5
    reset_dut();
    req = 6'b100001;
    step(12, 0);
    req = '0;
    step(6, 0);
    chk("t3_count_ok", (g_who.size() >= 3) ? 1 : 0, 1);
    if (g_who.size() >= 3) begin
      chk("t3_first", g_who[0], 0);
      chk("t3_second", g_who[1], 5);
      chk("t3_wrap", g_who[2], 0);
    end

    // watchdog abort on requester 2; req changes mid-operation
    reset_dut();
    mode = 1; dly = 0; req = 6'b000100;
    for (int i = 0; i < 10 && g_who.size() == 0; i++) step(1, 0);
    req = 6'b111111;
    for (int i = 0; i < 20 && terr_cyc < 0; i++) step(1, 0);
    acks_at_err = n_ack;
    dly = 1;
    step(6, 0);
    req = '0;
    step(6, 0);
    chk("t4_seen", (g_who.size() >= 2 && terr_cyc >= 0) ? 1 : 0, 1);
    if (g_who.size() >= 2 && terr_cyc >= 0) begin
      chk("t4_who", g_who[0], 2);
      chk("t4_wait_cycles", terr_cyc - g_cyc[0], TO + 1);
      chk("t4_next", g_who[1], 3);
    end
    chk("t4_no_ack", acks_at_err, 0);
    chk("t4_sticky", int'(timeout_err), 1);

    // done on the last permitted wait cycle wins over the watchdog
    reset_dut();
    mode = 1; dly = TO; req = 6'b000001;
    step(20, 1);
    chk("t5_acks", n_ack, 1);
    chk("t5_err", int'(timeout_err), 0);

    // reset during WAIT, then a late done
    reset_dut();
    mode = 0; man_done = 0; req = 6'b000001;
    for (int i = 0; i < 10 && g_who.size() == 0; i++) step(1, 0);
    step(2, 0);
    reset = 1'b1; req = '0;
    step(1, 0);
    reset = 1'b0; man_done = 1;
    step(1, 0);
    man_done = 0;
    step(5, 0);
    chk("t6_acks", n_ack, 0);
    chk("t6_grants", g_who.size(), 1);
    chk("t6_sel", int'(sel), 0);
    chk("t6_busy", int'(busy), 0);

    // random soak with stray dones and occasional resets
    reset_dut();
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 63));
      reset = ($urandom_range(0, 249) == 0);
      step(1, 0);
    end
    reset = 1'b0; req = '0; mode = 0;
    step(12, 0);
    chk("t7_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f32m_mux6_sched.md
F32M_MUX6_SCHED -- requirements
Module: f32m_mux6_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 6: number of requesters; equals the six select lines of the GF(3^{2M}) six-way operand mux.
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum WAIT cycles before abort; range 1..1023.
REQ-003 SHALL have parameter TW, default 10: width of the watchdog counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, N_REQ: req[i]=1 means requester i needs the shared GF(3^{2M}) unit; held high until ack[i].
REQ-007 SHALL have port sel, output, N_REQ: one-hot or zero; drives mux select lines l0..l5 (sel[i] to li).
REQ-008 SHALL have port unit_start, output, 1: one-cycle start pulse to the shared arithmetic unit.
REQ-009 SHALL have port unit_done, input, 1: completion pulse from the shared unit.
REQ-010 SHALL have port ack, output, N_REQ: one-cycle pulse to the served requester; result valid that cycle.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port timeout_err, output, 1: sticky abort flag, cleared only by reset.

Function
REQ-013 SHALL implement FSM IDLE -> GRANT -> WAIT -> ACK -> IDLE, all outputs registered.
REQ-014 IDLE: if req!=0, SHALL pick the first set req[i] searching round-robin from (last+1) mod N_REQ, register sel=onehot(i), go to GRANT; if req==0, stay in IDLE with sel=0.
REQ-015 GRANT: SHALL assert unit_start for exactly this one cycle, hold sel, clear the watchdog, go to WAIT.
REQ-016 WAIT: SHALL hold sel stable; unit_done=1 -> ACK; unit_done in IDLE, GRANT or ACK SHALL be ignored.
REQ-017 ACK: SHALL pulse ack[i] one cycle with sel still held, set last=i, then clear sel and go to IDLE.
REQ-018 SHALL keep sel unchanged from GRANT through ACK; req changes during this window SHALL NOT affect the grant in progress.
REQ-019 Req deasserted mid-operation: operation SHALL complete, and ack SHALL still pulse.
REQ-020 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, GRANT, WAIT, ACK) when unit_done arrives in the first WAIT cycle.
REQ-021 Watchdog: count WAIT cycles; at count==TIMEOUT without unit_done, SHALL set timeout_err, give no ack, clear sel, set last=i, return to IDLE.
REQ-022 unit_done on the same cycle the count reaches TIMEOUT: done SHALL win (normal ACK, no error).
REQ-023 Pointer wrap: after last=N_REQ-1, search SHALL start at 0.
REQ-024 sel SHALL never have more than one bit set; ack SHALL never have more than one bit set, and only with a matching sel.

Reset
REQ-025 reset=1 SHALL force IDLE, sel=0, ack=0, unit_start=0, busy=0, timeout_err=0, watchdog=0, last=N_REQ-1, so requester 0 has first priority.
REQ-026 Reset mid-operation SHALL abort without an ack pulse; the shared unit's late unit_done SHALL be ignored because the FSM is in IDLE.

Structure
REQ-027 State encoding, N_REQ and the TIMEOUT default SHALL live in a shared package alongside the field-width constants (M, WIDTH, W2).
REQ-028 SHALL contain one sub-module, rr_pick: combinational round-robin one-hot picker (req, last -> onehot).
REQ-029 SHALL be instantiated next to f32m_mux6, with sel[i] wired to li.

Verification
REQ-030 Reset, then req=6'b000001, unit_done 3 cycles after unit_start -> sel=000001 from GRANT, one unit_start pulse, ack=000001 exactly once, busy low afterwards.
REQ-031 req=6'b111111 held, immediate unit_done each time -> grants in order 0,1,2,3,4,5,0, each 4 cycles apart.
REQ-032 last=5, req=6'b100001 -> requester 0 granted; next pass -> requester 5.
REQ-033 Grant to requester 2, no unit_done, TIMEOUT=8 -> timeout_err=1 after 8 WAIT cycles, no ack, sel=0, next grant goes to 3 or later.
REQ-034 Reset asserted in WAIT, then unit_done pulsed -> all outputs 0, no ack, FSM stays IDLE.
REQ-035 Random req with stray unit_done in IDLE and GRANT -> at most one bit set in sel and in ack every cycle, no ack without a WAIT-state done.
